// File: rtl/mult_issue_ctrl_if.sv
// Operand stream, multiplier handshake and result stream of the issue stage.
// Pure wiring bundle: no storage, no latency of its own.
// Backpressure is carried by in_ready/out_ready; mul_busy gates new starts.
interface mult_issue_ctrl_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           mul_start;
  logic [N-1:0]   mul_multiplican;
  logic [N-1:0]   mul_multiplier;
  logic           mul_busy;
  logic           mul_done;
  logic [2*N-1:0] mul_product;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;
  logic [7:0]     out_seq;
  logic           out_err;

  // Environment side: operand producer, multiplier and result consumer.
  modport master (
    output in_valid, in_a, in_b, mul_busy, mul_done, mul_product, out_ready,
    input  in_ready, mul_start, mul_multiplican, mul_multiplier,
           out_valid, out_product, out_seq, out_err
  );

  // Issue controller side.
  modport slave (
    input  in_valid, in_a, in_b, mul_busy, mul_done, mul_product, out_ready,
    output in_ready, mul_start, mul_multiplican, mul_multiplier,
           out_valid, out_product, out_seq, out_err
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue stage for the Booth multiplier: queues operand pairs, starts one op, captures its product.
// Latency: push at edge k -> mul_start in cycle k+2; result valid the edge after done rises.
// Backpressure: in_ready = !full; a held result blocks the next start until out_ready.
module mult_issue_ctrl #(
  parameter int N       = 4,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  mult_issue_ctrl_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [7:0]   seq;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [7:0]      seq_cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            start_ok;

  logic [1:0]      state;
  logic            done_q;
  logic [TW-1:0]   tmo_cnt;
  logic [7:0]      pend_seq;
  logic            capture;
  logic            timeout;

  logic [N-1:0]    mul_a_r;
  logic [N-1:0]    mul_b_r;
  logic            out_valid_r;
  logic [2*N-1:0]  out_product_r;
  logic [7:0]      out_seq_r;
  logic            out_err_r;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Full blocks the push even if a pop happens at the same edge: no pass-through.
  assign push  = bus.in_valid && !full;
  assign head  = mem[rd_ptr];

  // A new op may start from IDLE, or straight out of HOLD on the result handshake.
  assign start_ok = !empty && !bus.mul_busy &&
                    ((state == S_IDLE) || ((state == S_HOLD) && bus.out_ready));

  // Only a fresh rising edge of done counts; a level left from the last op is ignored.
  assign capture = (state == S_WAIT) && bus.mul_done && !done_q;
  assign timeout = (state == S_WAIT) && !capture && (tmo_cnt == TMO_LAST);

  assign bus.in_ready        = !full;
  assign bus.mul_start       = (state == S_ISSUE);
  assign bus.mul_multiplican = mul_a_r;
  assign bus.mul_multiplier  = mul_b_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_product     = out_product_r;
  assign bus.out_seq         = out_seq_r;
  assign bus.out_err         = out_err_r;

  // Operand storage; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: bus.in_a, b: bus.in_b, seq: seq_cnt};
    end
  end

  // FIFO pointers, occupancy and the per-push sequence tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      seq_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        seq_cnt <= seq_cnt + 8'd1;
      end
      if (start_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, start_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue/capture FSM with the operand, watchdog and result registers it owns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      done_q        <= 1'b0;
      tmo_cnt       <= '0;
      pend_seq      <= '0;
      mul_a_r       <= '0;
      mul_b_r       <= '0;
      out_valid_r   <= 1'b0;
      out_product_r <= '0;
      out_seq_r     <= '0;
      out_err_r     <= 1'b0;
    end else begin
      done_q <= bus.mul_done;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            out_product_r <= bus.mul_product;
            out_seq_r     <= pend_seq;
            out_err_r     <= 1'b0;
            out_valid_r   <= 1'b1;
            state         <= S_HOLD;
          end else if (timeout) begin
            out_product_r <= '0;
            out_seq_r     <= pend_seq;
            out_err_r     <= 1'b1;
            out_valid_r   <= 1'b1;
            state         <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= start_ok ? S_ISSUE : S_IDLE;
          end
        end
      endcase

      if (start_ok) begin
        mul_a_r  <= head.a;
        mul_b_r  <= head.b;
        pend_seq <= head.seq;
        tmo_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl with a behavioural multiplier.
// Scoreboard predicts every result from the pushed operands and their tags.
// Directed scenarios first, then randomized operands with random consumer stalls.
module tb_mult_issue_ctrl;
  localparam int N       = 4;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 16;
  localparam int L       = N / 2 + 2;

  localparam int M_NORMAL = 0;
  localparam int M_STALE  = 1;
  localparam int M_NEVER  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_issue_ctrl_if #(.N(N)) bus();

  mult_issue_ctrl #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         starts      = 0;
  int         results     = 0;
  int         mode        = M_NORMAL;
  logic       push_err    = 1'b0;
  logic       rand_rdy    = 1'b0;
  logic [7:0] ref_seq     = 8'd0;

  typedef struct {
    logic [7:0] prod;
    logic [7:0] seq;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product: sign-extend both operands and multiply modulo 2^(2N).
  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    logic signed [7:0] p;
    ea = {{4{a[3]}}, a};
    eb = {{4{b[3]}}, b};
    p  = ea * eb;
    return p;
  endfunction

  // Multiplier model arithmetic, done in integers.
  function automatic logic [7:0] model_prod(input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    ia = a[3] ? int'(a) - 16 : int'(a);
    ib = b[3] ? int'(b) - 16 : int'(b);
    return 8'(ia * ib);
  endfunction

  // Behavioural multiplier: busy L cycles after start, then done.
  // STALE keeps the old done/product through the op and blips done low before the new result.
  // NEVER finishes busy but never raises done.
  int         m_cnt;
  int         m_mode;
  logic       m_drop;
  logic [7:0] m_next;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mul_busy    <= 1'b0;
      bus.mul_done    <= 1'b0;
      bus.mul_product <= '0;
      m_cnt           <= 0;
      m_mode          <= M_NORMAL;
      m_drop          <= 1'b0;
      m_next          <= '0;
    end else if (bus.mul_start) begin
      bus.mul_busy <= 1'b1;
      m_cnt        <= L;
      m_mode       <= mode;
      m_drop       <= 1'b0;
      m_next       <= model_prod(bus.mul_multiplican, bus.mul_multiplier);
      if (mode != M_STALE) bus.mul_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        bus.mul_busy <= 1'b0;
        if (m_mode == M_NORMAL) begin
          bus.mul_done    <= 1'b1;
          bus.mul_product <= m_next;
        end else if (m_mode == M_STALE) begin
          bus.mul_done <= 1'b0;
          m_drop       <= 1'b1;
        end
      end
    end else if (m_drop) begin
      m_drop          <= 1'b0;
      bus.mul_done    <= 1'b1;
      bus.mul_product <= m_next;
    end
  end

  // Scoreboard: record pushes, check every presented result, pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (bus.in_valid && bus.in_ready) begin
        e.prod = push_err ? 8'h00 : ref_prod(bus.in_a, bus.in_b);
        e.seq  = ref_seq;
        e.err  = push_err;
        exp_q.push_back(e);
        ref_seq = ref_seq + 8'd1;
      end
      if (bus.mul_start) begin
        starts++;
        chk("start_during_result", bus.out_valid, 0);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", bus.out_valid, 0);
        end else begin
          e = exp_q[0];
          chk("sb_product", bus.out_product, e.prod);
          chk("sb_seq", bus.out_seq, e.seq);
          chk("sb_err", bus.out_err, e.err);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            results++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic err);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    push_err     = err;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        tick();
        bus.in_valid = 1'b0;
        return;
      end
      tick();
    end
    chk("push_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_valid_timeout", bus.out_valid, 1);
  endtask

  task automatic drain();
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 600; w++) begin
      if (exp_q.size() == 0 && bus.out_valid === 1'b0) break;
      tick();
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", bus.out_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_mul_start"}, bus.mul_start, 0);
    chk({tag, "_mul_multiplican"}, bus.mul_multiplican, 0);
    chk({tag, "_mul_multiplier"}, bus.mul_multiplier, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_product"}, bus.out_product, 0);
    chk({tag, "_out_seq"}, bus.out_seq, 0);
    chk({tag, "_out_err"}, bus.out_err, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    exp_q.delete();
    ref_seq = 8'd0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0;
    int r0;
    int n;
    logic [7:0] sa;
    logic [3:0] ra;
    logic [3:0] rb;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    // Single op: latency, one start pulse, product 0x0F with tag 0.
    s0 = starts;
    r0 = results;
    push(4'd3, 4'd5, 1'b0);
    chk("lat_push_edge_start", bus.mul_start, 0);
    tick();
    chk("lat_k2_start", bus.mul_start, 1);
    chk("issue_multiplican", bus.mul_multiplican, 3);
    chk("issue_multiplier", bus.mul_multiplier, 5);
    tick();
    chk("start_one_cycle", bus.mul_start, 0);
    wait_valid();
    chk("single_product", bus.out_product, 8'h0F);
    chk("single_seq", bus.out_seq, 0);
    chk("single_err", bus.out_err, 0);
    drain();
    chk("single_start_count", starts - s0, 1);
    chk("single_result_count", results - r0, 1);

    // Signed ops back-to-back; FIFO fills at two entries then drains.
    do_reset("rst2");
    push(4'hD, 4'h5, 1'b0);
    push(4'h8, 4'h8, 1'b0);
    push(4'h7, 4'hF, 1'b0);
    chk("fifo_full_in_ready", bus.in_ready, 0);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("in_ready_recovers", bus.in_ready, 1);
    drain();

    // Backpressure: result held stable for 10 cycles, no start until handshake.
    bus.out_ready = 1'b0;
    sa = ref_seq;
    push(4'h6, 4'h3, 1'b0);
    push(4'hB, 4'h2, 1'b0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_product", bus.out_product, 8'h12);
      chk("bp_seq", bus.out_seq, sa);
      chk("bp_no_start", bus.mul_start, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", bus.out_valid, 0);
    chk("bp_release_start", bus.mul_start, 1);
    drain();

    // Stale done: done held high across ops; each op captured once with its own product.
    mode = M_STALE;
    s0   = starts;
    r0   = results;
    push(4'd3, 4'd5, 1'b0);
    push(4'd2, 4'd2, 1'b0);
    push(4'hF, 4'hF, 1'b0);
    drain();
    chk("stale_start_count", starts - s0, 3);
    chk("stale_result_count", results - r0, 3);
    mode = M_NORMAL;

    // Timeout: never-done op forces an error result 16 cycles after entering WAIT.
    bus.out_ready = 1'b0;
    mode = M_NEVER;
    push(4'h5, 4'h5, 1'b1);
    push(4'h2, 4'h3, 1'b0);
    n = 0;
    while (bus.mul_start !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("timeout_start_seen", bus.mul_start, 1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    mode = M_NORMAL;
    chk("timeout_latency", n, 17);
    chk("timeout_err", bus.out_err, 1);
    chk("timeout_product", bus.out_product, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("after_timeout_issue", bus.mul_start, 1);
    drain();

    // Reset mid-WAIT with two queued ops: everything discarded, tags restart.
    push(4'd1, 4'd1, 1'b0);
    push(4'd2, 4'd1, 1'b0);
    push(4'd3, 4'd1, 1'b0);
    do_reset("mid_wait");
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_rst_no_result", bus.out_valid, 0);
      chk("post_rst_no_start", bus.mul_start, 0);
    end
    push(4'h6, 4'hE, 1'b0);
    wait_valid();
    chk("post_rst_seq", bus.out_seq, 0);
    chk("post_rst_product", bus.out_product, 8'hF4);
    drain();

    // Randomized operands, multiplier behaviour and consumer stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 1);
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      push(ra, rb, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    mode = M_NORMAL;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Upstream issue and downstream result-capture stage for the bit-pair Booth multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one start pulse per operand pair to the multiplier, then waits for its done.
- Captures the 2N-bit product and presents it on a valid/ready output stream with a sequence tag.
- A watchdog flags a multiplier that never completes.

Parameters:
- N, 4, operand width; must match the multiplier's N.
- DEPTH, 2, operand FIFO entries; power of two, ≥2.
- TIMEOUT, 64, maximum cycles in WAIT before an error result is forced; must exceed multiplier latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  N  multiplicand, two's complement.
- in_b  in  N  multiplier, two's complement.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_multiplican  out  N  registered multiplicand to the multiplier.
- mul_multiplier  out  N  registered multiplier operand.
- mul_busy  in  1  multiplier busy.
- mul_done  in  1  multiplier done; may be a level held until the next start.
- mul_product  in  2N  multiplier product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2N  captured product.
- out_seq  out  8  tag of the operand pair that produced this result.
- out_err  out  1  result was forced by timeout; out_product is 0.

Behaviour:
Reset (rst=0), asynchronous:
- FIFO emptied; state IDLE; seq counter 0.
- in_ready=1, mul_start=0, mul_multiplican=0, mul_multiplier=0.
- out_valid=0, out_product=0, out_seq=0, out_err=0.
- Reset mid-operation discards the in-flight op and all queued ops; no output is produced for them.

Input and FIFO:
- Push on in_valid&in_ready; the entry stores {in_a, in_b, seq}; seq increments by 1 per push, wrapping 255→0.
- in_ready=!full. When full, no push occurs even if a pop happens the same cycle (no pass-through).
- Push and pop in the same cycle are allowed when not full; count is unchanged.
- No bypass: a pair pushed at edge k is first visible at the FIFO head after edge k.

FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if FIFO non-empty and !mul_busy → ISSUE. At the same edge: pop the head, load mul_multiplican/mul_multiplier and the pending seq, clear the timeout counter.
- ISSUE: mul_start=1 for exactly this one cycle (decoded from state). Next state is WAIT unconditionally.
- WAIT: done_q registers mul_done every cycle. Capture fires on the rising edge (mul_done & !done_q); a level left over from the previous op is ignored.
  - On capture: out_product←mul_product, out_seq←pending seq, out_err←0, out_valid←1, → HOLD.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1: out_product←0, out_err←1, out_valid←1, → HOLD.
  - If a capture and the timeout occur in the same cycle, the capture wins.
- HOLD: out_valid=1 and all out_* stable until out_ready.
  - On out_valid&out_ready, out_valid drops next cycle.
  - If the FIFO is non-empty and !mul_busy at that edge → ISSUE (same pop/load as IDLE); else → IDLE.
- mul_done outside WAIT is ignored; done_q still tracks it.
- Latency: push at edge k with the FSM idle and multiplier free gives mul_start high in cycle k+2 (edge k+1 enters ISSUE).
- Throughput: at most one op in flight. A result must be consumed before the next start.

Arithmetic:
- The block passes products through unchanged. It does no sign handling.
- out_product is exactly the 2N-bit two's-complement product reported by the multiplier.

Test Plan:
Bench uses a behavioural multiplier model: busy for L=N/2+2 cycles after start, then done held high until the next start. N=4.
- Single op: a=3, b=5 → exactly one mul_start pulse, then out_valid with out_product=8'h0F, out_seq=0, out_err=0. mul_start is seen two cycles after the push edge.
- Signed ops: (-3,5), (-8,-8), (7,-1) pushed back-to-back → products 8'hF1, 8'h40, 8'hF9 in order with out_seq 0,1,2. in_ready drops after two queued entries (DEPTH=2) and recovers after a pop.
- Backpressure: out_ready=0 for 10 cycles → out_product and out_seq stable and no new mul_start during the stall. mul_start comes after the out_ready handshake.
- Stale done: model holds done high across ops → each op captured once. The product must come from the new op, not a repeat of the previous result.
- Timeout: model never raises done, TIMEOUT=16 → out_valid 16 cycles after entering WAIT with out_err=1, out_product=0. The next queued op then issues normally.
- Reset mid-WAIT with 2 queued ops: rst low for 1 cycle → all outputs at their reset values and in_ready=1. No result appears for the discarded ops, and out_seq restarts at 0 on the next push.
